// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pkg                                                         |
// | Purpose  : Shared VGA timing presets, control-bit struct and size helpers. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vga_pkg;

    // 800x600 @ 72 Hz, positive syncs
    localparam int c_SVGA_H_ACTIVE = 800;
    localparam int c_SVGA_H_FP     = 56;
    localparam int c_SVGA_H_SYNC   = 120;
    localparam int c_SVGA_H_BP     = 64;
    localparam int c_SVGA_V_ACTIVE = 600;
    localparam int c_SVGA_V_FP     = 37;
    localparam int c_SVGA_V_SYNC   = 6;
    localparam int c_SVGA_V_BP     = 23;
    localparam bit c_SVGA_HS_POL   = 1'b1;
    localparam bit c_SVGA_VS_POL   = 1'b1;

    // 640x480 @ 60 Hz, negative syncs
    localparam int c_VGA_H_ACTIVE  = 640;
    localparam int c_VGA_H_FP      = 16;
    localparam int c_VGA_H_SYNC    = 96;
    localparam int c_VGA_H_BP      = 48;
    localparam int c_VGA_V_ACTIVE  = 480;
    localparam int c_VGA_V_FP      = 10;
    localparam int c_VGA_V_SYNC    = 2;
    localparam int c_VGA_V_BP      = 33;
    localparam bit c_VGA_HS_POL    = 1'b0;
    localparam bit c_VGA_VS_POL    = 1'b0;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_ctl_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int vga_cnt_w(input int active, input int fp, input int sync, input int bp);
        return $clog2(vga_total(active, fp, sync, bp));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen_if                                               |
// | Purpose  : Framebuffer read port: pixel request out, colour data back.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vga_timing_gen_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 4
);
    logic               req_valid;
    logic [X_W-1:0]     req_x;
    logic [Y_W-1:0]     req_y;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    modport master (output req_valid, req_x, req_y, input pix_r, pix_g, pix_b);
    modport slave  (input req_valid, req_x, req_y, output pix_r, pix_g, pix_b);
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_axis_counter                                                |
// | Purpose  : One raster axis: wrapping position counter plus region decode.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FP     = 56,
    parameter int SYNC   = 120,
    parameter int BP     = 64
) (
    input  wire                                       clk,
    input  wire                                       rst_n,
    input  wire                                       i_step,
    output logic [vga_cnt_w(ACTIVE, FP, SYNC, BP)-1:0] o_cnt,
    output logic                                      o_active,
    output logic                                      o_sync_raw,
    output logic                                      o_wrap
);
    localparam int c_TOTAL = vga_total(ACTIVE, FP, SYNC, BP);
    localparam int c_CW    = vga_cnt_w(ACTIVE, FP, SYNC, BP);

    localparam logic [c_CW-1:0] c_LAST      = c_CW'(c_TOTAL - 1);
    localparam logic [c_CW-1:0] c_ACT_END   = c_CW'(ACTIVE);
    localparam logic [c_CW-1:0] c_SYNC_BEG  = c_CW'(ACTIVE + FP);
    localparam logic [c_CW-1:0] c_SYNC_END  = c_CW'(ACTIVE + FP + SYNC);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CW'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_active   = (r_cnt < c_ACT_END);
    assign o_sync_raw = (r_cnt >= c_SYNC_BEG) && (r_cnt < c_SYNC_END);
    assign o_wrap     = i_step && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Purpose  : VGA raster timing, pixel request and latency-aligned pin stage. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_SVGA_H_ACTIVE,
    parameter int H_FP     = c_SVGA_H_FP,
    parameter int H_SYNC   = c_SVGA_H_SYNC,
    parameter int H_BP     = c_SVGA_H_BP,
    parameter int V_ACTIVE = c_SVGA_V_ACTIVE,
    parameter int V_FP     = c_SVGA_V_FP,
    parameter int V_SYNC   = c_SVGA_V_SYNC,
    parameter int V_BP     = c_SVGA_V_BP,
    parameter bit HS_POL   = c_SVGA_HS_POL,
    parameter bit VS_POL   = c_SVGA_VS_POL,
    parameter int COLOR_W  = 4,
    parameter int RD_LAT   = 1
) (
    input  wire                 MAX10_CLK1_50,
    input  wire                 RESET_N,
    input  wire                 pix_en,
    vga_timing_gen_if.master    fb,
    output logic                line_start,
    output logic                frame_start,
    output logic [COLOR_W-1:0]  VGA_R,
    output logic [COLOR_W-1:0]  VGA_G,
    output logic [COLOR_W-1:0]  VGA_B,
    output logic                VGA_HS,
    output logic                VGA_VS
);
    localparam int c_HW = vga_cnt_w(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_VW = vga_cnt_w(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_XW = $clog2(H_ACTIVE);
    localparam int c_YW = $clog2(V_ACTIVE);

    generate
        if (RD_LAT < 1 || RD_LAT > 4 ||
            H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
            $fatal(1, "vga_timing_gen: RD_LAT must be 1..4 and all timing values nonzero");
        end
    endgenerate

    logic [c_HW-1:0] w_h_cnt;
    logic [c_VW-1:0] w_v_cnt;
    logic            w_h_active, w_h_sync, w_h_wrap;
    logic            w_v_active, w_v_sync, w_v_wrap;
    logic            w_v_step, w_active;
    vga_ctl_t        w_ctl_d;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk        (MAX10_CLK1_50),
        .rst_n      (RESET_N),
        .i_step     (pix_en),
        .o_cnt      (w_h_cnt),
        .o_active   (w_h_active),
        .o_sync_raw (w_h_sync),
        .o_wrap     (w_h_wrap)
    );

    assign w_v_step = w_h_wrap & pix_en;

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk        (MAX10_CLK1_50),
        .rst_n      (RESET_N),
        .i_step     (w_v_step),
        .o_cnt      (w_v_cnt),
        .o_active   (w_v_active),
        .o_sync_raw (w_v_sync),
        .o_wrap     (w_v_wrap)
    );

    // Frame wrap is implied by (0,0) decode; kept on the port for other users.
    logic w_unused_ok;
    assign w_unused_ok = w_v_wrap;

    assign w_active     = w_h_active & w_v_active;
    assign fb.req_valid = w_active;
    assign fb.req_x     = w_active ? w_h_cnt[c_XW-1:0] : '0;
    assign fb.req_y     = w_active ? w_v_cnt[c_YW-1:0] : '0;

    // Counters sit at (0,0) during reset, so the pulses are also held off by RESET_N.
    assign line_start  = RESET_N & pix_en & (w_h_cnt == '0);
    assign frame_start = line_start & (w_v_cnt == '0);

    vga_ctl_t r_dly [RD_LAT];

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else if (pix_en) begin
            r_dly[0] <= '{active: w_active, hs: w_h_sync, vs: w_v_sync};
            for (int i = 1; i < RD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_ctl_d = r_dly[RD_LAT-1];

    logic [COLOR_W-1:0] r_vga_r, r_vga_g, r_vga_b;
    logic               r_vga_hs, r_vga_vs;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_hs <= ~HS_POL;
            r_vga_vs <= ~VS_POL;
        end else if (pix_en) begin
            r_vga_r  <= w_ctl_d.active ? fb.pix_r : '0;
            r_vga_g  <= w_ctl_d.active ? fb.pix_g : '0;
            r_vga_b  <= w_ctl_d.active ? fb.pix_b : '0;
            r_vga_hs <= w_ctl_d.hs ? HS_POL : ~HS_POL;
            r_vga_vs <= w_ctl_d.vs ? VS_POL : ~VS_POL;
        end
    end

    assign VGA_R  = r_vga_r;
    assign VGA_G  = r_vga_g;
    assign VGA_B  = r_vga_b;
    assign VGA_HS = r_vga_hs;
    assign VGA_VS = r_vga_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                               |
// | Purpose  : Two small-raster instances (positive/negative syncs) vs a model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;
    localparam int A_HA = 16, A_HF = 3, A_HS = 5, A_HB = 4;
    localparam int A_VA = 10, A_VF = 2, A_VS = 3, A_VB = 2, A_LAT = 3;
    localparam int B_HA = 12, B_HF = 2, B_HS = 4, B_HB = 3;
    localparam int B_VA = 8,  B_VF = 1, B_VS = 2, B_VB = 2, B_LAT = 1;
    localparam int CW = 4;

    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, lat; } tcfg_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W($clog2(A_HA)), .Y_W($clog2(A_VA)), .COLOR_W(CW)) fb_a ();
    vga_timing_gen_if #(.X_W($clog2(B_HA)), .Y_W($clog2(B_VA)), .COLOR_W(CW)) fb_b ();

    logic          line_a, frame_a, hs_a, vs_a, line_b, frame_b, hs_b, vs_b;
    logic [CW-1:0] r_a, g_a, b_a, r_b, g_b, b_b;

    vga_timing_gen #(.H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
                     .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
                     .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(CW), .RD_LAT(A_LAT)) u_dut_a (
        .MAX10_CLK1_50(clk), .RESET_N(rst_n), .pix_en(pix_en), .fb(fb_a),
        .line_start(line_a), .frame_start(frame_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a));

    vga_timing_gen #(.H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                     .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
                     .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .RD_LAT(B_LAT)) u_dut_b (
        .MAX10_CLK1_50(clk), .RESET_N(rst_n), .pix_en(pix_en), .fb(fb_b),
        .line_start(line_b), .frame_start(frame_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b));

    tcfg_t cfg_a, cfg_b;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_en     = 0;   // enabled edges since reset release = raster position index
    bit    en_prev  = 1'b0;
    bit    agg_on   = 1'b1;
    int    agg_hs [2];
    int    agg_vs [2];
    int    ring_v [2][8];
    int    ring_x [2][8];
    int    ring_y [2][8];

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void pos(input tcfg_t c, input int n, output int h, output int v);
        int ht, vt;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        h  = n % ht;
        v  = (n / ht) % vt;
    endfunction

    // Framebuffer image content
    function automatic int fb_pix(input int x, input int y, input int ch);
        return (x * (ch + 1) + y * (2 * ch + 3) + 5 * ch) % 16;
    endfunction

    // Data the framebuffer presents now: the pixel requested lat enabled cycles ago, else garbage
    function automatic int fb_data(input int id, input tcfg_t c, input int ch);
        int q;
        q = n_en - c.lat;
        if (q >= 0 && ring_v[id][q % 8] != 0)
            return fb_pix(ring_x[id][q % 8], ring_y[id][q % 8], ch);
        return int'($urandom_range(1, 15));
    endfunction

    task automatic sample_inst(input int id, input tcfg_t c, input bit fresh,
                               input logic rv, input logic [31:0] rx, input logic [31:0] ry,
                               input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                               input logic hs, input logic vs);
        int  h, v, p, eh, ev, ehs, evs, er, eg, eb;
        bit  act, pact;
        string nm;
        nm = (id == 0) ? "A" : "B";
        pos(c, n_en, h, v);
        act = (h < c.ha) && (v < c.va);
        chk({nm, ".req_valid"}, 32'(rv), int'(act));
        chk({nm, ".req_x"}, rx, act ? h : 0);
        chk({nm, ".req_y"}, ry, act ? v : 0);
        ring_v[id][n_en % 8] = int'(rv);
        ring_x[id][n_en % 8] = int'(rx);
        ring_y[id][n_en % 8] = int'(ry);
        p = n_en - c.lat - 1;
        if (p < 0) begin
            ehs = 1 - c.hp; evs = 1 - c.vp; er = 0; eg = 0; eb = 0;
        end else begin
            pos(c, p, eh, ev);
            pact = (eh < c.ha) && (ev < c.va);
            ehs  = (eh >= c.ha + c.hf && eh < c.ha + c.hf + c.hs) ? c.hp : 1 - c.hp;
            evs  = (ev >= c.va + c.vf && ev < c.va + c.vf + c.vs) ? c.vp : 1 - c.vp;
            er   = pact ? fb_pix(eh, ev, 0) : 0;
            eg   = pact ? fb_pix(eh, ev, 1) : 0;
            eb   = pact ? fb_pix(eh, ev, 2) : 0;
        end
        chk({nm, ".VGA_HS"}, 32'(hs), ehs);
        chk({nm, ".VGA_VS"}, 32'(vs), evs);
        chk({nm, ".VGA_R"}, r, er);
        chk({nm, ".VGA_G"}, g, eg);
        chk({nm, ".VGA_B"}, b, eb);
        if (agg_on && fresh && n_en >= c.lat + 1 &&
            n_en < c.lat + 1 + (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb)) begin
            if (int'(hs) == c.hp) agg_hs[id]++;
            if (int'(vs) == c.vp) agg_vs[id]++;
        end
    endtask

    task automatic check_pulses(input int id, input tcfg_t c, input logic ls, input logic fs);
        int h, v;
        pos(c, n_en, h, v);
        chk((id == 0) ? "A.line_start" : "B.line_start", 32'(ls), int'(pix_en && h == 0));
        chk((id == 0) ? "A.frame_start" : "B.frame_start", 32'(fs), int'(pix_en && h == 0 && v == 0));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".A.pins"}, {r_a, g_a, b_a, 20'(0)}, 0);
        chk({tag, ".A.HS"}, 32'(hs_a), 0);
        chk({tag, ".A.VS"}, 32'(vs_a), 0);
        chk({tag, ".B.pins"}, {r_b, g_b, b_b, 20'(0)}, 0);
        chk({tag, ".B.HS"}, 32'(hs_b), 1);
        chk({tag, ".B.VS"}, 32'(vs_b), 1);
        chk({tag, ".pulses"}, {28'(0), line_a, frame_a, line_b, frame_b}, 0);
        chk({tag, ".A.req"}, {fb_a.req_valid, 27'(0), fb_a.req_x}, 32'h8000_0000);
        chk({tag, ".B.req_y"}, 32'(fb_b.req_y), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        pix_en = 1'b1;
        #1 check_idle("reset_now");
        repeat (2) @(negedge clk);
        #1 check_idle("reset_hold");
        rst_n   = 1'b1;
        pix_en  = 1'b0;
        en_prev = 1'b0;
        n_en    = 0;
    endtask

    // mode 0: always enabled, 1: enabled every other clock, 2: random 3-of-4
    task automatic run(input int cycles, input int mode);
        bit fresh;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            fresh = en_prev;
            if (en_prev) n_en++;
            sample_inst(0, cfg_a, fresh, fb_a.req_valid, 32'(fb_a.req_x), 32'(fb_a.req_y),
                        32'(r_a), 32'(g_a), 32'(b_a), hs_a, vs_a);
            sample_inst(1, cfg_b, fresh, fb_b.req_valid, 32'(fb_b.req_x), 32'(fb_b.req_y),
                        32'(r_b), 32'(g_b), 32'(b_b), hs_b, vs_b);
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = (i % 2 == 0);
                default: pix_en = ($urandom_range(0, 3) != 0);
            endcase
            fb_a.pix_r = CW'(fb_data(0, cfg_a, 0));
            fb_a.pix_g = CW'(fb_data(0, cfg_a, 1));
            fb_a.pix_b = CW'(fb_data(0, cfg_a, 2));
            fb_b.pix_r = CW'(fb_data(1, cfg_b, 0));
            fb_b.pix_g = CW'(fb_data(1, cfg_b, 1));
            fb_b.pix_b = CW'(fb_data(1, cfg_b, 2));
            #1;
            check_pulses(0, cfg_a, line_a, frame_a);
            check_pulses(1, cfg_b, line_b, frame_b);
            en_prev = pix_en;
        end
    endtask

    initial begin
        cfg_a = '{A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1, 1, A_LAT};
        cfg_b = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 0, 0, B_LAT};
        agg_hs = '{0, 0};
        agg_vs = '{0, 0};
        fb_a.pix_r = '0; fb_a.pix_g = '0; fb_a.pix_b = '0;
        fb_b.pix_r = '0; fb_b.pix_g = '0; fb_b.pix_b = '0;

        do_reset();
        run(1000, 0);
        // One full frame of pins: sync asserted sync_width x other-axis-total times
        chk("A.hs_per_frame", 32'(agg_hs[0]), A_HS * (A_VA + A_VF + A_VS + A_VB));
        chk("A.vs_per_frame", 32'(agg_vs[0]), A_VS * (A_HA + A_HF + A_HS + A_HB));
        chk("B.hs_per_frame", 32'(agg_hs[1]), B_HS * (B_VA + B_VF + B_VS + B_VB));
        chk("B.vs_per_frame", 32'(agg_vs[1]), B_VS * (B_HA + B_HF + B_HS + B_HB));
        agg_on = 1'b0;

        run(800, 1);
        run(337, 2);
        do_reset();
        run(1200, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage for the DE10-Lite board. It is the successor to the fixed 800x600 red-screen test block. Porches, sync widths, sync polarities, colour depth and framebuffer read latency are all generics. It issues a pixel request with (x, y) ahead of display time, and it aligns the returned framebuffer data with HS/VS at the pins. It sits between the framebuffer/VRAM read port and the VGA connector pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync pulse (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync pulse (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, HS level during the sync pulse (1 = positive)
VS_POL, 1, VS level during the sync pulse
COLOR_W, 4, bits per colour channel
RD_LAT, 1, framebuffer read latency in enabled cycles (legal range 1..4)

Ports:
MAX10_CLK1_50  in  1  system clock; all logic on posedge
RESET_N  in  1  asynchronous, active-low reset
pix_en  in  1  pixel-clock enable; all state advances only when 1
req_valid  out  1  pixel request; high when the current counter position is active video
req_x  out  clog2(H_ACTIVE)  requested column, 0..H_ACTIVE-1
req_y  out  clog2(V_ACTIVE)  requested row, 0..V_ACTIVE-1
pix_r / pix_g / pix_b  in  COLOR_W each  framebuffer data, valid RD_LAT enabled cycles after req
line_start  out  1  one-cycle pulse at h_cnt==0 when pix_en=1
frame_start  out  1  one-cycle pulse at h_cnt==0, v_cnt==0 when pix_en=1
VGA_R / VGA_G / VGA_B  out  COLOR_W each  registered colour to pins
VGA_HS  out  1  registered horizontal sync
VGA_VS  out  1  registered vertical sync

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 666). Counter widths are clog2 of each total.
- Line order on both axes is active, front porch, sync, back porch. h_cnt 0..H_ACTIVE-1 is active. HS is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. V uses the same rule on v_cnt.
- Counter stepping, only when pix_en=1:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on that h wrap, and wraps from V_TOTAL-1 to 0.
  - No counter ever reaches a total value.
- When pix_en=0, every register holds, including outputs and the delay line. Pulses are gated by pix_en.
- req_valid, req_x and req_y are decoded combinationally from the counter registers. req_x = h_cnt and req_y = v_cnt when active; both are 0 when not active.
- Alignment pipeline: an RD_LAT-deep shift register of {active, hs_raw, vs_raw} advances on pix_en.
- Output register, on pix_en:
  - VGA_HS = hs_d ? HS_POL : ~HS_POL. VS uses the same rule with VS_POL.
  - VGA_R/G/B = active_d ? pix_* : 0.
- Latency from counter position to pins is RD_LAT+1 enabled cycles, for syncs and colour alike.
- Blanking: colour outputs are forced to 0 in every non-active position, regardless of the pix_* values.
- Reset (asynchronous assert, synchronous-safe release):
  - h_cnt = v_cnt = 0 and the delay line is cleared.
  - VGA_R/G/B = 0, VGA_HS = ~HS_POL, VGA_VS = ~VS_POL.
  - line_start = frame_start = 0.
  - Reset mid-frame restarts at pixel (0,0) on the first enabled cycle after release, and frame_start fires there.
- Elaboration check: RD_LAT outside 1..4, or any timing parameter equal to 0, is a fatal error.

Decomposition:
- Shared package vga_pkg:
  - default timing constants for 800x600@72 (values above) and 640x480@60 (640/16/96/48, 480/10/2/33, negative polarity)
  - a helper function for total and counter width
- One sub-module, vga_axis_counter:
  - parametrised by ACTIVE/FP/SYNC/BP
  - inputs: step; outputs: cnt, active, sync_raw, wrap
  - instantiated twice; the vertical instance is stepped by the horizontal wrap AND pix_en.

Test Plan:
1. Defaults, pix_en=1, pix_r=F: VGA_HS is high for exactly 120 cycles per 1040. VGA_VS is high for exactly 6 lines of 666. Red=F for exactly 800 cycles per line and 600 lines; zero elsewhere.
2. Latency, RD_LAT=3, pix_r driven as req_x[3:0] delayed 3 cycles: VGA_R equals the (x mod 16) pattern and starts exactly 4 cycles after the first req_valid of the line.
3. pix_en toggling 1-of-2 cycles: periods double to 2080 clocks per line. Outputs and counters hold on pix_en=0 cycles. No pulses occur on disabled cycles.
4. Polarity, 640x480 package constants (HS_POL=VS_POL=0): idle HS/VS=1. 96-cycle HS low pulse. 2-line VS low pulse. 800x525 totals.
5. Reset asserted at h_cnt=500, v_cnt=300: outputs go immediately to 0/idle sync. After release, frame_start pulses on the first enabled cycle and req_x=0, req_y=0.
6. Boundary wraps: at h_cnt=1039, v_cnt=665, the next enabled cycle gives h=0, v=0, line_start=1, frame_start=1. Nonzero pix_* inputs during porches never reach the pins.
